// File: rtl/pokey_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : pokey_key_debounce
// Purpose  : Keyboard debounce and KBCODE latch for POKEY. Watches the
//            keyboard scan (index plus kr1_L/kr2_L return lines, qualified by
//            scan_strobe). A key is confirmed when it is seen pressed at the
//            same index on two consecutive scan passes. The confirmed code is
//            latched with the CTRL/SHIFT modifiers and a keyboard IRQ is
//            raised. Key-held, IRQ pending and overrun status are also kept.
// Ports    : o2          - system clock (phase 2), rising edge active
//            rst         - asynchronous active-high reset
//            scan_strobe - key_scan/kr1_L/kr2_L valid this cycle
//            key_scan    - index of the key being scanned (0..63)
//            kr1_L       - return line 1, low = key at key_scan pressed
//            kr2_L       - return line 2, low = modifier at key_scan pressed
//            irq_en      - keyboard IRQ enable
//            irq_clr     - one-cycle pulse clearing irq_pending/overrun
//            kbcode      - {ctrl, shift, key[5:0]} of the last accepted key
//            key_depr    - a debounced key is currently held
//            shift_held  - latched SHIFT state
//            irq_pending - sticky keyboard interrupt request
//            overrun     - sticky: key accepted while IRQ already pending
// Revision : 1.0 - initial release
// ============================================================================
module pokey_key_debounce #(
    parameter logic [5:0] SHIFT_IDX = 6'd16,
    parameter logic [5:0] CTRL_IDX  = 6'd0
) (
    input  logic       o2,
    input  logic       rst,
    input  logic       scan_strobe,
    input  logic [5:0] key_scan,
    input  logic       kr1_L,
    input  logic       kr2_L,
    input  logic       irq_en,
    input  logic       irq_clr,
    output logic [7:0] kbcode,
    output logic       key_depr,
    output logic       shift_held,
    output logic       irq_pending,
    output logic       overrun
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_DEBOUNCE = 2'd1;
    localparam logic [1:0] c_HELD     = 2'd2;
    localparam logic [1:0] c_RELEASE  = 2'd3;

    logic [1:0] r_state;
    logic [5:0] r_cmp;
    logic [7:0] r_kbcode;
    logic       r_key_depr;
    logic       r_shift_held;
    logic       r_ctrl_l;
    logic       r_irq_pending;
    logic       r_overrun;

    logic [1:0] w_state_next;
    logic       w_at_cmp;
    logic       w_cmp_load;
    logic       w_accept;
    logic       w_release;
    logic       w_irq_pending_next;
    logic       w_overrun_next;

    // Only strobes at the captured index can advance the debounce sequence.
    assign w_at_cmp = scan_strobe && (key_scan == r_cmp);

    always_comb begin
        w_state_next = r_state;
        w_cmp_load   = 1'b0;
        w_accept     = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (scan_strobe && !kr1_L) begin
                    w_cmp_load   = 1'b1;
                    w_state_next = c_DEBOUNCE;
                end
            end
            c_DEBOUNCE: begin
                if (w_at_cmp) begin
                    if (!kr1_L) begin
                        w_accept     = 1'b1;
                        w_state_next = c_HELD;
                    end else begin
                        w_state_next = c_IDLE;
                    end
                end
            end
            c_HELD: begin
                // Other keys pressed while one is held are ignored.
                if (w_at_cmp && kr1_L) begin
                    w_state_next = c_RELEASE;
                end
            end
            c_RELEASE: begin
                if (w_at_cmp) begin
                    if (kr1_L) begin
                        w_release    = 1'b1;
                        w_state_next = c_IDLE;
                    end else begin
                        w_state_next = c_HELD;
                    end
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // A clear pulse is applied first and an accept then overrides it, so a
    // coincident accept still leaves the IRQ set. Overrun looks at the
    // pre-clear pending flag.
    always_comb begin
        w_irq_pending_next = irq_clr ? 1'b0 : r_irq_pending;
        w_overrun_next     = irq_clr ? 1'b0 : r_overrun;
        if (w_accept && irq_en) begin
            w_irq_pending_next = 1'b1;
            if (r_irq_pending) begin
                w_overrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge o2 or posedge rst) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_cmp         <= 6'd0;
            r_kbcode      <= 8'h00;
            r_key_depr    <= 1'b0;
            r_shift_held  <= 1'b0;
            r_ctrl_l      <= 1'b0;
            r_irq_pending <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_irq_pending <= w_irq_pending_next;
            r_overrun     <= w_overrun_next;

            if (w_cmp_load) begin
                r_cmp <= key_scan;
            end

            // The accept uses the modifier values registered before this
            // strobe; a modifier update in the same strobe is seen next time.
            if (w_accept) begin
                r_kbcode   <= {r_ctrl_l, r_shift_held, r_cmp};
                r_key_depr <= 1'b1;
            end else if (w_release) begin
                r_key_depr <= 1'b0;
            end

            if (scan_strobe && (key_scan == SHIFT_IDX)) begin
                r_shift_held <= ~kr2_L;
            end
            if (scan_strobe && (key_scan == CTRL_IDX)) begin
                r_ctrl_l <= ~kr2_L;
            end
        end
    end

    assign kbcode      = r_kbcode;
    assign key_depr    = r_key_depr;
    assign shift_held  = r_shift_held;
    assign irq_pending = r_irq_pending;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pokey_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_pokey_key_debounce
// Purpose  : Self-checking bench for pokey_key_debounce. Each scenario task
//            drives whole 64-step scan passes, pushes the expected status
//            {kbcode, key_depr, shift_held, irq_pending, overrun} into a
//            scoreboard queue and pops/compares it after the pass.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pokey_key_debounce;

    logic       o2 = 1'b0;
    logic       rst = 1'b1;
    logic       scan_strobe = 1'b0;
    logic [5:0] key_scan = 6'd0;
    logic       kr1_L = 1'b1;
    logic       kr2_L = 1'b1;
    logic       irq_en = 1'b1;
    logic       irq_clr = 1'b0;
    logic [7:0] kbcode;
    logic       key_depr;
    logic       shift_held;
    logic       irq_pending;
    logic       overrun;

    pokey_key_debounce #(.SHIFT_IDX(6'd16), .CTRL_IDX(6'd0)) dut (
        .o2          (o2),
        .rst         (rst),
        .scan_strobe (scan_strobe),
        .key_scan    (key_scan),
        .kr1_L       (kr1_L),
        .kr2_L       (kr2_L),
        .irq_en      (irq_en),
        .irq_clr     (irq_clr),
        .kbcode      (kbcode),
        .key_depr    (key_depr),
        .shift_held  (shift_held),
        .irq_pending (irq_pending),
        .overrun     (overrun)
    );

    always #5 o2 = ~o2;

    localparam int c_NO_CLR    = -1;
    localparam int c_CLR_PULSE = 64;

    typedef struct {
        string       name;
        logic [63:0] keys;
        logic [63:0] mods;
        int          clr;
        logic        en;
        logic [11:0] exp;
    } step_t;

    typedef struct {
        string       name;
        logic [11:0] val;
    } exp_t;

    step_t steps[$];
    exp_t  sb[$];
    exp_t  e;
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic logic [63:0] k(input int i);
        return 64'd1 << i;
    endfunction

    function automatic logic [11:0] obs();
        return {kbcode, key_depr, shift_held, irq_pending, overrun};
    endfunction

    task automatic add(input string name, input logic [63:0] keys,
                       input logic [63:0] mods, input int clr,
                       input logic en, input logic [11:0] exp);
        step_t s;
        s.name = name; s.keys = keys; s.mods = mods;
        s.clr = clr; s.en = en; s.exp = exp;
        steps.push_back(s);
    endtask

    task automatic strobe(input int idx, input logic k1, input logic k2,
                          input logic clr);
        @(posedge o2); #1;
        scan_strobe = 1'b1;
        key_scan    = 6'(idx);
        kr1_L       = k1;
        kr2_L       = k2;
        irq_clr     = clr;
        @(posedge o2); #1;
        scan_strobe = 1'b0;
        irq_clr     = 1'b0;
        kr1_L       = 1'b1;
        kr2_L       = 1'b1;
    endtask

    task automatic do_pass(input logic [63:0] keys, input logic [63:0] mods,
                           input int clr_idx);
        for (int i = 0; i < 64; i++) begin
            strobe(i, ~keys[i], ~mods[i], (i == clr_idx));
        end
    endtask

    task automatic run_step(input step_t s);
        irq_en = s.en;
        if (s.clr == c_CLR_PULSE) begin
            @(posedge o2); #1;
            irq_clr = 1'b1;
            @(posedge o2); #1;
            irq_clr = 1'b0;
        end else begin
            do_pass(s.keys, s.mods, s.clr);
        end
    endtask

    task automatic test_reset();
        @(posedge o2); #1;
        rst = 1'b0;
        sb.push_back('{"reset_values", 12'h000});
        e = sb.pop_front();
        n_checks++;
        if (obs() !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
        end
        // Key 5 detected, then an asynchronous reset pulse between edges.
        do_pass(k(5), 64'd0, c_NO_CLR);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        sb.push_back('{"reset_mid_debounce", 12'h000});
        e = sb.pop_front();
        n_checks++;
        if (obs() !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
        end
        steps.delete();
        add("after_reset_no_accept", k(5),  64'd0, c_NO_CLR, 1'b1, 12'h000);
        add("after_reset_bounce",    64'd0, 64'd0, c_NO_CLR, 1'b1, 12'h000);
        foreach (steps[i]) begin
            sb.push_back('{steps[i].name, steps[i].exp});
            run_step(steps[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
            end
        end
    endtask

    task automatic test_non_strobe();
        // Inputs that would matter on a strobe are ignored without one.
        key_scan = 6'd16;
        kr1_L    = 1'b0;
        kr2_L    = 1'b0;
        sb.push_back('{"non_strobe_hold", 12'h000});
        repeat (8) @(posedge o2);
        #1;
        kr1_L = 1'b1;
        kr2_L = 1'b1;
        e = sb.pop_front();
        n_checks++;
        if (obs() !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
        end
    endtask

    task automatic test_clean_press();
        steps.delete();
        add("clean_first_pass", k(12), 64'd0, c_NO_CLR,    1'b1, 12'h000);
        add("clean_accept",     k(12), 64'd0, c_NO_CLR,    1'b1, 12'h0CA);
        add("clean_release1",   64'd0, 64'd0, c_NO_CLR,    1'b1, 12'h0CA);
        add("clean_release2",   64'd0, 64'd0, c_NO_CLR,    1'b1, 12'h0C2);
        add("clean_irq_clr",    64'd0, 64'd0, c_CLR_PULSE, 1'b1, 12'h0C0);
        foreach (steps[i]) begin
            sb.push_back('{steps[i].name, steps[i].exp});
            run_step(steps[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
            end
        end
    endtask

    task automatic test_bounce();
        steps.delete();
        add("bounce_press",      k(12), 64'd0, c_NO_CLR,    1'b1, 12'h0C0);
        add("bounce_reject",     64'd0, 64'd0, c_NO_CLR,    1'b1, 12'h0C0);
        add("bounce_idle_p1",    k(9),  64'd0, c_NO_CLR,    1'b1, 12'h0C0);
        add("bounce_idle_p2",    k(9),  64'd0, c_NO_CLR,    1'b1, 12'h09A);
        add("bounce_rel1",       64'd0, 64'd0, c_NO_CLR,    1'b1, 12'h09A);
        add("bounce_rel2",       64'd0, 64'd0, c_NO_CLR,    1'b1, 12'h092);
        add("bounce_clr",        64'd0, 64'd0, c_CLR_PULSE, 1'b1, 12'h090);
        foreach (steps[i]) begin
            sb.push_back('{steps[i].name, steps[i].exp});
            run_step(steps[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
            end
        end
    endtask

    task automatic test_shift_ctrl();
        logic [63:0] m;
        m = k(16) | k(0);
        steps.delete();
        add("mod_first_pass", k(33), m,     c_NO_CLR,    1'b1, 12'h094);
        add("mod_accept",     k(33), m,     c_NO_CLR,    1'b1, 12'hE1E);
        add("mod_release1",   64'd0, 64'd0, c_NO_CLR,    1'b1, 12'hE1A);
        add("mod_release2",   64'd0, 64'd0, c_NO_CLR,    1'b1, 12'hE12);
        add("mod_clr",        64'd0, 64'd0, c_CLR_PULSE, 1'b1, 12'hE10);
        foreach (steps[i]) begin
            sb.push_back('{steps[i].name, steps[i].exp});
            run_step(steps[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
            end
        end
    endtask

    task automatic test_irq_disabled();
        steps.delete();
        add("irqoff_p1",     k(1),  64'd0, c_NO_CLR, 1'b0, 12'hE10);
        add("irqoff_accept", k(1),  64'd0, c_NO_CLR, 1'b0, 12'h018);
        add("irqoff_rel1",   64'd0, 64'd0, c_NO_CLR, 1'b0, 12'h018);
        add("irqoff_rel2",   64'd0, 64'd0, c_NO_CLR, 1'b1, 12'h010);
        foreach (steps[i]) begin
            sb.push_back('{steps[i].name, steps[i].exp});
            run_step(steps[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
            end
        end
    endtask

    task automatic test_overrun();
        steps.delete();
        add("ovr_k3_p1",        k(3),  64'd0, c_NO_CLR,    1'b1, 12'h010);
        add("ovr_k3_accept",    k(3),  64'd0, c_NO_CLR,    1'b1, 12'h03A);
        add("ovr_k3_rel1",      64'd0, 64'd0, c_NO_CLR,    1'b1, 12'h03A);
        add("ovr_k3_rel2",      64'd0, 64'd0, c_NO_CLR,    1'b1, 12'h032);
        add("ovr_k7_p1",        k(7),  64'd0, c_NO_CLR,    1'b1, 12'h032);
        add("ovr_k7_overrun",   k(7),  64'd0, c_NO_CLR,    1'b1, 12'h07B);
        add("ovr_clr",          64'd0, 64'd0, c_CLR_PULSE, 1'b1, 12'h078);
        add("ovr_k7_rel1",      64'd0, 64'd0, c_NO_CLR,    1'b1, 12'h078);
        add("ovr_k7_rel2",      64'd0, 64'd0, c_NO_CLR,    1'b1, 12'h070);
        add("sim_k3_p1",        k(3),  64'd0, c_NO_CLR,    1'b1, 12'h070);
        add("sim_k3_accept",    k(3),  64'd0, c_NO_CLR,    1'b1, 12'h03A);
        add("sim_k3_rel1",      64'd0, 64'd0, c_NO_CLR,    1'b1, 12'h03A);
        add("sim_k3_rel2",      64'd0, 64'd0, c_NO_CLR,    1'b1, 12'h032);
        add("sim_k7_p1",        k(7),  64'd0, c_NO_CLR,    1'b1, 12'h032);
        add("sim_clr_accept",   k(7),  64'd0, 7,           1'b1, 12'h07B);
        add("sim_k7_rel1",      64'd0, 64'd0, c_NO_CLR,    1'b1, 12'h07B);
        add("sim_k7_rel2",      64'd0, 64'd0, c_NO_CLR,    1'b1, 12'h073);
        add("sim_final_clr",    64'd0, 64'd0, c_CLR_PULSE, 1'b1, 12'h070);
        foreach (steps[i]) begin
            sb.push_back('{steps[i].name, steps[i].exp});
            run_step(steps[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
            end
        end
    endtask

    task automatic test_hold_no_rollover();
        logic [63:0] h;
        h = k(20) | k(40);
        steps.delete();
        add("hold_p1",          h,     64'd0, c_NO_CLR,    1'b1, 12'h070);
        add("hold_accept",      h,     64'd0, c_NO_CLR,    1'b1, 12'h14A);
        add("hold_pass2",       h,     64'd0, c_NO_CLR,    1'b1, 12'h14A);
        add("hold_pass3",       h,     64'd0, c_NO_CLR,    1'b1, 12'h14A);
        add("hold_clr",         h,     64'd0, c_CLR_PULSE, 1'b1, 12'h148);
        add("hold_one_release", k(40), 64'd0, c_NO_CLR,    1'b1, 12'h148);
        add("hold_rebounce",    h,     64'd0, c_NO_CLR,    1'b1, 12'h148);
        add("hold_again",       h,     64'd0, c_NO_CLR,    1'b1, 12'h148);
        add("hold_rel1",        64'd0, 64'd0, c_NO_CLR,    1'b1, 12'h148);
        add("hold_rel2",        64'd0, 64'd0, c_NO_CLR,    1'b1, 12'h140);
        foreach (steps[i]) begin
            sb.push_back('{steps[i].name, steps[i].exp});
            run_step(steps[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_non_strobe();
        test_clean_press();
        test_bounce();
        test_shift_ctrl();
        test_irq_disabled();
        test_overrun();
        test_hold_no_rollover();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/pokey_key_debounce.md
Name: pokey_key_debounce

Overview:
- Keyboard debounce and KBCODE latch stage for POKEY; sits directly downstream of the I/O control block's keyboard scan.
- Consumes the 6-bit scan index plus the kr1_L/kr2_L return lines sampled on each scan step.
- Confirms a key by seeing it on two consecutive passes at the same index.
- Latches KBCODE with shift/ctrl, raises a keyboard IRQ, and tracks key-held, pending and overrun status for the register read path.

Parameters:
- SHIFT_IDX, 6'd16: scan index at which kr2_L low means SHIFT is held.
- CTRL_IDX, 6'd0: scan index at which kr2_L low means CTRL is held.

Ports:
- o2  in  1  system clock (phase-2); all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- scan_strobe  in  1  high for one o2 cycle when key_scan/kr1_L/kr2_L are valid for the current scan step.
- key_scan  in  6  index of the key currently being scanned (0-63).
- kr1_L  in  1  key return line 1, active low; key at key_scan is pressed.
- kr2_L  in  1  key return line 2, active low; modifier at key_scan is pressed.
- irq_en  in  1  keyboard IRQ enable (IRQEN bit).
- irq_clr  in  1  one-cycle pulse; clears irq_pending and overrun.
- kbcode  out  8  {ctrl, shift, key[5:0]} of the last accepted key.
- key_depr  out  1  a debounced key is currently held.
- shift_held  out  1  current latched SHIFT state.
- irq_pending  out  1  sticky keyboard interrupt request.
- overrun  out  1  sticky: a key was accepted while irq_pending was already 1.

Behaviour:
- Reset (async, any time, including mid-debounce): state=IDLE, cmp=0, kbcode=8'h00, key_depr=0, shift_held=0, ctrl_l=0, irq_pending=0, overrun=0.
- All inputs are acted on only in cycles with scan_strobe=1; non-strobe cycles hold all state. The only exception is irq_clr, which acts on any cycle.
- Modifier latch, every strobe:
  - key_scan==SHIFT_IDX: shift_held <= ~kr2_L.
  - key_scan==CTRL_IDX: ctrl_l <= ~kr2_L.
  - This happens independent of FSM state.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE. cmp is a 6-bit compare latch.
  - IDLE: strobe with kr1_L=0 -> cmp <= key_scan, go DEBOUNCE. Otherwise stay.
  - DEBOUNCE: only strobes with key_scan==cmp matter; others are ignored.
    - kr1_L=0 -> accept: kbcode <= {ctrl_l, shift_held, cmp}, key_depr <= 1, go HELD.
    - kr1_L=1 -> go IDLE (bounce rejected, no outputs change).
  - HELD: strobe at cmp with kr1_L=1 -> go RELEASE; kr1_L=0 -> stay. Presses at other indices are ignored (no rollover).
  - RELEASE: strobe at cmp with kr1_L=1 -> key_depr <= 0, go IDLE; kr1_L=0 -> go HELD (release bounce).
- Modifier values used at accept: ctrl_l and shift_held as registered before the accepting strobe. A modifier updated in the same strobe is not seen; the accepting strobe's key_scan equals cmp, so it cannot also be a modifier index unless cmp equals that index.
- Accept event, in the same cycle as the kbcode update:
  - If irq_en=1: irq_pending <= 1.
  - If irq_pending was already 1: overrun <= 1.
  - If irq_en=0: kbcode and key_depr still update; irq_pending and overrun are unchanged.
- irq_clr and accept in the same cycle: set wins; irq_pending=1 and overrun per the rule above, evaluated on the pre-clear value.
- irq_clr alone: irq_pending <= 0, overrun <= 0 on the next edge.
- Latency:
  - kbcode, key_depr, irq_pending are valid on the posedge after the confirming strobe, i.e. one full 64-step scan after first detection.
  - key_depr falls one scan after the first released sample.
- key_scan wraps 63->0 under external control; the block makes no assumption about scan order beyond the index compare.

Test Plan:
- Reset mid-DEBOUNCE: key 5 detected, then rst pulse -> all outputs 0, state IDLE; the next strobe at 5 with kr1_L=0 re-enters DEBOUNCE and does not accept.
- Clean press: kr1_L=0 at index 12 on two consecutive passes, irq_en=1, no modifiers -> after the second strobe at 12: kbcode=8'h0C, key_depr=1, irq_pending=1, overrun=0.
- Bounce rejection: index 12 pressed on pass 1, released on pass 2 -> state IDLE; kbcode, key_depr and irq_pending unchanged.
- Shift+ctrl: kr2_L=0 at indices 16 and 0 each pass; key 33 pressed on two passes -> kbcode=8'hE1, shift_held=1.
- Overrun and clear:
  - Accept key 3, then release (key_depr=0 after two released passes).
  - Accept key 7 without irq_clr -> kbcode=8'h07, overrun=1.
  - Pulse irq_clr -> irq_pending=0, overrun=0.
  - Simultaneous irq_clr and accept -> irq_pending=1.
- Hold/no-rollover: key 20 held for 3 passes while key 40 is also pressed -> kbcode stays 8'h14, irq_pending set once; a single released pass at 20 followed by a pressed pass -> key_depr stays 1, no new IRQ.
